// File: rtl/accel_loader.sv
// Host-side loader: streams headers/payload into the accelerator's instruction and data
// memories and sequences a run. ACCEL_LOADER_CHECKSUM_EN enables the payload XOR checksum.
module accel_loader #(
  parameter int NUM_SIZE   = 16,
  parameter int BUFFER_LEN = 32,
  parameter int ADDR_W     = $clog2(BUFFER_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [23:0]         in_data,
  output logic                instr_we,
  output logic [ADDR_W-1:0]   instr_addr,
  output logic [23:0]         instr_wdata,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [NUM_SIZE-1:0] mem_wdata,
  output logic                start,
  input  logic                accel_busy,
  input  logic                accel_done,
  output logic                run_done,
  output logic                err,
  output logic [23:0]         checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN_WAIT,
    S_RUN_START,
    S_RUN_BUSY
  } state_t;

  state_t state_q, state_d;

  logic                tgt_q, tgt_d;  // 1 = data memory, 0 = instruction memory
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                instr_we_q, instr_we_d;
  logic [ADDR_W-1:0]   instr_addr_q, instr_addr_d;
  logic [23:0]         instr_wdata_q, instr_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [NUM_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                start_q, start_d;
  logic                run_done_q, run_done_d;
  logic                err_q, err_d;

  logic accept;
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    instr_we_d    = 1'b0;
    instr_addr_d  = instr_addr_q;
    instr_wdata_d = instr_wdata_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    start_d       = 1'b0;
    run_done_d    = 1'b0;
    err_d         = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (in_data[23:22])
            2'd0, 2'd1: begin
              tgt_d   = in_data[22];
              addr_d  = in_data[ADDR_W+7:8];
              cnt_d   = in_data[7:0];
              state_d = S_LOAD;
            end
            2'd2:    state_d = S_RUN_WAIT;
            default: err_d   = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (tgt_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = in_data[NUM_SIZE-1:0];
          end else begin
            instr_we_d    = 1'b1;
            instr_addr_d  = addr_q;
            instr_wdata_d = in_data;
          end
          addr_d = (addr_q == ADDR_W'(BUFFER_LEN - 1)) ? '0 : addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = S_IDLE;
        end
      end
      S_RUN_WAIT: begin
        if (!accel_busy) begin
          start_d = 1'b1;
          state_d = S_RUN_START;
        end
      end
      S_RUN_START: state_d = S_RUN_BUSY;
      S_RUN_BUSY: begin
        if (accel_done) begin
          run_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // in_ready is registered, so it is derived from the state being entered
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tgt_q         <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      instr_we_q    <= 1'b0;
      instr_addr_q  <= '0;
      instr_wdata_q <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      start_q       <= 1'b0;
      run_done_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      instr_we_q    <= instr_we_d;
      instr_addr_q  <= instr_addr_d;
      instr_wdata_q <= instr_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      start_q       <= start_d;
      run_done_q    <= run_done_d;
      err_q         <= err_d;
    end
  end

`ifdef ACCEL_LOADER_CHECKSUM_EN
  logic [23:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept && state_q == S_LOAD) begin
      checksum_d = checksum_q ^ in_data;
    end else if (accept && state_q == S_IDLE && in_data[23:22] == 2'd2) begin
      checksum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign in_ready    = in_ready_q;
  assign instr_we    = instr_we_q;
  assign instr_addr  = instr_addr_q;
  assign instr_wdata = instr_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign start       = start_q;
  assign run_done    = run_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_accel_loader.sv
// Directed self-checking bench for accel_loader; checksum checks follow ACCEL_LOADER_CHECKSUM_EN.
module tb_accel_loader;

  localparam int NUM_SIZE   = 16;
  localparam int BUFFER_LEN = 32;
  localparam int ADDR_W     = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [23:0]         in_data;
  logic                instr_we;
  logic [ADDR_W-1:0]   instr_addr;
  logic [23:0]         instr_wdata;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [NUM_SIZE-1:0] mem_wdata;
  logic                start;
  logic                accel_busy;
  logic                accel_done;
  logic                run_done;
  logic                err;
  logic [23:0]         checksum;

  int unsigned nvec = 0;
  int unsigned nmis = 0;
  logic [23:0] exp_ck;
  logic [23:0] dwords [8];

  accel_loader #(
    .NUM_SIZE  (NUM_SIZE),
    .BUFFER_LEN(BUFFER_LEN),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .instr_we   (instr_we),
    .instr_addr (instr_addr),
    .instr_wdata(instr_wdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .start      (start),
    .accel_busy (accel_busy),
    .accel_done (accel_done),
    .run_done   (run_done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_ck(input string tag);
`ifdef ACCEL_LOADER_CHECKSUM_EN
    chk(tag, {8'h0, checksum}, {8'h0, exp_ck});
`else
    chk(tag, {8'h0, checksum}, 32'h0);
`endif
  endtask

  initial begin
    dwords[0] = 24'd3; dwords[1] = 24'd1; dwords[2] = 24'd4; dwords[3] = 24'd1;
    dwords[4] = 24'd2; dwords[5] = 24'd1; dwords[6] = 24'd7; dwords[7] = 24'd8;
    exp_ck     = '0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    accel_busy = 1'b0;
    accel_done = 1'b0;

    // reset state
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_instr_we", instr_we, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_start", start, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_err", err, 0);
    chk("rst_instr_addr", instr_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_checksum", checksum, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // instruction load, base 4
    in_valid = 1'b1;
    in_data  = 24'h000400;
    tick();
    chk("ihdr_no_we", instr_we, 0);
    in_data = 24'h040440;
    tick();
    exp_ck ^= 24'h040440;
    chk("i4_we", instr_we, 1);
    chk("i4_addr", instr_addr, 4);
    chk("i4_data", instr_wdata, 32'h040440);
    chk("i4_mem_we", mem_we, 0);
    in_data = 24'h000700;
    tick();
    chk("ihdr2_no_we", instr_we, 0);
    in_data = 24'h280000;
    tick();
    exp_ck ^= 24'h280000;
    chk("i7_we", instr_we, 1);
    chk("i7_addr", instr_addr, 7);
    chk("i7_opcode", instr_wdata[23:18], 10);

    // data load of 8 words, no bubbles
    in_data = 24'h400007;
    tick();
    chk("dhdr_no_we", mem_we, 0);
    for (int i = 0; i < 8; i++) begin
      in_data = dwords[i];
      tick();
      exp_ck ^= dwords[i];
      chk("d_we", mem_we, 1);
      chk("d_addr", mem_addr, i);
      chk("d_data", mem_wdata, dwords[i]);
      chk("d_instr_we", instr_we, 0);
      chk("d_ready", in_ready, 1);
    end
    chk_ck("ck_after_data");

    // wrap-around: base 30, 4 words
    in_data = 24'h401E03;
    tick();
    chk("whdr_no_we", mem_we, 0);
    for (int i = 0; i < 4; i++) begin
      in_data = 24'h11 + 24'(i);
      tick();
      exp_ck ^= 24'h11 + 24'(i);
      chk("w_we", mem_we, 1);
      chk("w_addr", mem_addr, (30 + i) % 32);
      chk("w_data", mem_wdata, 32'h11 + i);
    end
    in_valid = 1'b0;
    tick();
    chk("w_idle_we", mem_we, 0);
    chk_ck("ck_after_wrap");

    // run with core busy for 5 cycles
    accel_busy = 1'b1;
    in_valid   = 1'b1;
    in_data    = 24'h800000;
    tick();
    exp_ck = '0;
    chk_ck("ck_run_clear");
    chk("run_ready_low", in_ready, 0);
    in_data = 24'hC00000;  // must be ignored while in_ready is low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_no_start", start, 0);
      chk("busy_ready_low", in_ready, 0);
    end
    accel_busy = 1'b0;
    tick();
    chk("start_pulse", start, 1);
    accel_busy = 1'b1;
    tick();
    chk("start_one_cycle", start, 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("rb_no_start", start, 0);
      chk("rb_no_done", run_done, 0);
      chk("rb_ready_low", in_ready, 0);
    end
    in_valid   = 1'b0;
    accel_done = 1'b1;
    tick();
    chk("run_done_pulse", run_done, 1);
    chk("run_ready_back", in_ready, 1);
    accel_done = 1'b0;
    accel_busy = 1'b0;
    tick();
    chk("run_done_one_cycle", run_done, 0);
    chk("no_err_from_blocked", err, 0);

    // illegal header, then a valid block
    in_valid = 1'b1;
    in_data  = 24'hC00000;
    tick();
    chk("illegal_err", err, 1);
    chk("illegal_ready", in_ready, 1);
    in_data = 24'h000300;
    tick();
    chk("err_sticky1", err, 1);
    chk("ihdr3_no_we", instr_we, 0);
    in_data = 24'h123456;
    tick();
    exp_ck ^= 24'h123456;
    chk("i3_we", instr_we, 1);
    chk("i3_addr", instr_addr, 3);
    chk("i3_data", instr_wdata, 32'h123456);
    chk("err_sticky2", err, 1);

    // reset after 2 of 8 words
    in_data = 24'h400807;
    tick();
    in_data = 24'h0000A1;
    tick();
    exp_ck ^= 24'h0000A1;
    chk("r_we0", mem_we, 1);
    chk("r_addr0", mem_addr, 8);
    in_data = 24'h0000A2;
    tick();
    exp_ck ^= 24'h0000A2;
    chk("r_we1", mem_we, 1);
    chk("r_addr1", mem_addr, 9);
    chk("r_data1", mem_wdata, 32'hA2);
    chk_ck("ck_before_rst");
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    exp_ck = '0;
    chk("r_rst_we", mem_we, 0);
    chk("r_rst_err", err, 0);
    chk_ck("ck_after_rst");
    rst = 1'b0;
    tick();
    chk("r_no_late_we", mem_we, 0);
    in_valid = 1'b1;
    in_data  = 24'h000500;
    tick();
    chk("r_hdr_no_mem_we", mem_we, 0);
    chk("r_hdr_no_instr_we", instr_we, 0);
    in_data = 24'h0000AB;
    tick();
    chk("r_i5_we", instr_we, 1);
    chk("r_i5_addr", instr_addr, 5);
    chk("r_i5_mem_we", mem_we, 0);
    in_valid = 1'b0;
    tick();
    chk("final_start", start, 0);
    chk("final_run_done", run_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/accel_loader.md
# accel_loader

Host-side loader that writes programs and operands into the accelerator's instruction and data memories, then launches and tracks a run. It consumes a 24-bit valid/ready command stream from the host. It drives the accelerator's instruction-memory and data-memory write ports, plus `start`. It sits between the host link and the `accelerator` core, in the opposite direction to the core's instruction fetch and memory read.

## Interface
- `NUM_SIZE`, 16: data-memory word width; must be ≤ 24.
- `BUFFER_LEN`, 32: depth of both the instruction and data memories.
- `ADDR_W`, `$clog2(BUFFER_LEN)`: memory address width.
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: host word valid.
- `in_ready` out 1: loader can accept a word.
- `in_data` in 24: host word, either a header or a payload word.
- `instr_we` out 1: instruction-memory write strobe.
- `instr_addr` out ADDR_W: instruction write address.
- `instr_wdata` out 24: instruction word, using the core's format: [23:18] opcode, [17:13] A, [12:8] B, [7:3] C, [2:0] flags.
- `mem_we` out 1: data-memory write strobe.
- `mem_addr` out ADDR_W: data write address.
- `mem_wdata` out NUM_SIZE: data word, taken from `in_data[NUM_SIZE-1:0]`.
- `start` out 1: one-cycle run pulse to the core.
- `accel_busy` in 1: core is executing.
- `accel_done` in 1: core has reached halt. It is a level that the core clears on `start`.
- `run_done` out 1: one-cycle pulse when a run completes.
- `err` out 1: sticky flag for an illegal header; cleared only by `rst`.
- `checksum` out 24: payload XOR. It is only meaningful with `ACCEL_LOADER_CHECKSUM_EN`.

## Operation
- Header fields:
  - [23:22] kind: 0 = instruction block, 1 = data block, 2 = run, 3 = illegal.
  - [15:8] base address; only the low ADDR_W bits are used.
  - [7:0] length minus 1, giving 1..256 payload words.
- Other header bits are ignored.
- States: IDLE, LOAD, RUN_WAIT, RUN_START, RUN_BUSY.
- IDLE:
  - `in_ready`=1.
  - An accepted header of kind 0 or 1 latches the target, base, and count, then goes to LOAD.
  - Kind 2 goes to RUN_WAIT.
  - Kind 3 sets `err` and stays in IDLE; the word is consumed.
- LOAD:
  - `in_ready`=1.
  - Each accepted word produces exactly one write to the latched target, at the current address.
  - The address increments modulo BUFFER_LEN, so base 30 with length 4 writes 30, 31, 0, 1.
  - After the last word is accepted, the state returns to IDLE.
- RUN_WAIT: `in_ready`=0; waits until `accel_busy`=0.
- RUN_START: `start`=1 for exactly one cycle, then RUN_BUSY.
- RUN_BUSY:
  - `in_ready`=0.
  - `accel_done` is sampled starting with the first RUN_BUSY cycle.
  - When it is high: `run_done`=1 for one cycle, then IDLE.
- A word is accepted only when `in_valid && in_ready` at a rising edge.
- `in_data` changing while `in_ready`=0 has no effect.
- Reset mid-LOAD or mid-run:
  - Returns to IDLE and discards the remaining count.
  - Writes already issued stand.
  - No `start` or `run_done` follows.

## Timing
- Reset values: `in_ready`=0 in the reset cycle, then 1 (IDLE). `instr_we`, `mem_we`, `start`, `run_done`, `err` = 0. Addresses, wdata and `checksum` = 0.
- All outputs are registered. A payload word accepted at edge N gives `*_we`=1 with addr/wdata valid for the cycle after edge N.
- At most one write per cycle. `instr_we` and `mem_we` are never high together.
- Back-to-back throughput is one word per cycle, including header→payload and last-payload→next-header with no bubble.
- Run sequence: a run header accepted at edge N with `accel_busy`=0 gives `start` high in the cycle after edge N+1.
- `run_done` is high in the cycle after the edge at which `accel_done` is sampled high in RUN_BUSY.

## Configuration
- `ACCEL_LOADER_CHECKSUM_EN` defined:
  - `checksum` XORs every accepted payload word (full 24 bits).
  - A run header clears it to 0 at acceptance.
- Not defined: `checksum` is constant 0 and no checksum logic is synthesized.

## Test plan
- Instruction load: headers 0x000400, then 0x040440 → `instr_we`, addr 4, data 0x040440 (opcode 1, A=0, B=4, C=8). Then headers 0x000700, then 0x280000 → addr 7, opcode 10.
- Data load: header 0x400007 with payload 3, 1, 4, 1, 2, 1, 7, 8 streamed with `in_valid` held high → eight consecutive `mem_we` cycles, addr 0..7, `mem_wdata` matching, no bubbles.
- Wrap-around: header 0x401E03 with 4 words → `mem_addr` 30, 31, 0, 1.
- Run: hold `accel_busy`=1 for 5 cycles after header 0x800000 → no `start` until busy drops, then a single `start` pulse. Raise `accel_done` 20 cycles later → one `run_done` pulse, and `in_ready` returns to 1.
- Illegal header 0xC00000 → `err`=1 and stays 1. A following valid block still loads correctly.
- Reset after 2 of 8 words of a data block → exactly 2 writes. The next word is treated as a header. With the macro enabled, `checksum` equals the XOR of the accepted words and is 0 after reset.
